// File: rtl/ark_pkg.sv
// Shared types and constants for the AES AddRoundKey engine.
package ark_pkg;

    localparam int BLOCK_W = 128;

    typedef logic [BLOCK_W-1:0] aes_block_t;

    typedef enum logic [1:0] {
        ARK_IDLE,
        ARK_XOR,
        ARK_HOLD
    } ark_state_e;

    // Number of XOR beats needed to cover one block at the given lane width.
    function automatic int beats(input int lane_w);
        return BLOCK_W / lane_w;
    endfunction

endpackage

// File: rtl/ark_key_bank.sv
// Round-key register file: one synchronous write port, one asynchronous read port.
// Out-of-range writes are dropped; out-of-range reads return zero with rvalid low.
module ark_key_bank
    import ark_pkg::*;
#(
    parameter int NUM_KEYS = 15,
    parameter int KIDX_W   = $clog2(NUM_KEYS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [KIDX_W-1:0] widx,
    input  aes_block_t        wdata,
    input  logic [KIDX_W-1:0] ridx,
    output aes_block_t        rdata,
    output logic              rvalid
);

    // One extra bit so NUM_KEYS itself fits when it is a power of two.
    localparam logic [KIDX_W:0] NUM_KEYS_V = (KIDX_W + 1)'(NUM_KEYS);

    aes_block_t mem_q [NUM_KEYS];
    aes_block_t mem_d [NUM_KEYS];
    logic       w_ok;

    // Next-state of the key array: update only the addressed, in-range slot.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        mem_d = mem_q;
        w_ok  = ({1'b0, widx} < NUM_KEYS_V);
        if (we && w_ok) begin
            mem_d[widx] = wdata;
        end
        rvalid = ({1'b0, ridx} < NUM_KEYS_V);
        rdata  = rvalid ? mem_q[ridx] : '0;
    end

    // Key storage register; cleared on reset so stale keys never leak across a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: this memory is deliberately reset (keys must read zero after reset), which rules out RAM-macro inference.
        if (!rst_n) begin
            mem_q <= '{default: '0};
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/ark_engine.sv
// AES AddRoundKey engine: latches a state and a snapshot of the selected round key,
// XORs them LANE_W bits per cycle (LSB lane first), then holds the result until taken.
module ark_engine
    import ark_pkg::*;
#(
    parameter int LANE_W   = 32,
    parameter int NUM_KEYS = 15,
    parameter int KIDX_W   = $clog2(NUM_KEYS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_we,
    input  logic [KIDX_W-1:0] key_widx,
    input  aes_block_t        key_wdata,
    input  logic              in_valid,
    output logic              in_ready,
    input  aes_block_t        in_state,
    input  logic [KIDX_W-1:0] in_kidx,
    output logic              out_valid,
    input  logic              out_ready,
    output aes_block_t        out_state,
    output logic              out_err,
    output logic              busy
);

    localparam int                BEATS     = beats(LANE_W);
    localparam int                BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    ark_state_e        state_q, state_d;
    logic [BEAT_W-1:0] beat_q,  beat_d;
    aes_block_t        blk_q,   blk_d;
    aes_block_t        key_q,   key_d;
    logic              err_q,   err_d;
    aes_block_t        bank_rdata;
    logic              bank_rvalid;

    ark_key_bank #(
        .NUM_KEYS (NUM_KEYS),
        .KIDX_W   (KIDX_W)
    ) u_key_bank (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (key_we),
        .widx   (key_widx),
        .wdata  (key_wdata),
        .ridx   (in_kidx),
        .rdata  (bank_rdata),
        .rvalid (bank_rvalid)
    );

    // FSM next-state, lane XOR and handshake outputs.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        blk_d   = blk_q;
        key_d   = key_q;
        err_d   = err_q;

        in_ready  = (state_q == ARK_IDLE) || ((state_q == ARK_HOLD) && out_ready);
        out_valid = (state_q == ARK_HOLD);
        busy      = (state_q != ARK_IDLE);
        out_err   = out_valid && err_q;
        out_state = blk_q;

        case (state_q)
            ARK_IDLE: ;
            ARK_XOR: begin
                for (int b = 0; b < BEATS; b++) begin
                    if (beat_q == BEAT_W'(b)) begin
                        blk_d[b*LANE_W +: LANE_W] = blk_q[b*LANE_W +: LANE_W] ^ key_q[b*LANE_W +: LANE_W];
                    end
                end
                if (beat_q == LAST_BEAT) begin
                    state_d = ARK_HOLD;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            ARK_HOLD: begin
                if (out_ready) begin
                    state_d = ARK_IDLE;
                end
            end
            default: state_d = ARK_IDLE;
        endcase

        // Accept overrides the HOLD->IDLE exit so back-to-back transactions skip IDLE.
        // The key is read from the pre-edge bank contents, so a same-cycle write is not seen.
        if (in_valid && in_ready) begin
            state_d = ARK_XOR;
            beat_d  = '0;
            blk_d   = in_state;
            key_d   = bank_rdata;
            err_d   = !bank_rvalid;
        end
    end

    // State, beat counter and transaction snapshot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARK_IDLE;
            beat_q  <= '0;
            blk_q   <= '0;
            key_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            blk_q   <= blk_d;
            key_q   <= key_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_ark_engine.sv
// Self-checking bench for ark_engine: directed steps with a scoreboard queue of expected results.
module tb_ark_engine;
    import ark_pkg::*;

    localparam int NUM_KEYS = 15;
    localparam int KIDX_W   = 4;

    localparam aes_block_t FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam aes_block_t FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam aes_block_t FIPS_CT  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;

    typedef struct {
        aes_block_t st;
        logic       err;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              key_we;
    logic [KIDX_W-1:0] key_widx;
    aes_block_t        key_wdata;
    logic              in_valid, in_valid_8, in_valid_128;
    logic              in_ready, in_ready_8, in_ready_128;
    aes_block_t        in_state;
    logic [KIDX_W-1:0] in_kidx;
    logic              out_valid, out_valid_8, out_valid_128;
    logic              out_ready;
    aes_block_t        out_state, out_state_8, out_state_128;
    logic              out_err, out_err_8, out_err_128;
    logic              busy, busy_8, busy_128;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    ark_engine #(.LANE_W(32), .NUM_KEYS(NUM_KEYS), .KIDX_W(KIDX_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .key_we(key_we), .key_widx(key_widx), .key_wdata(key_wdata),
        .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state), .in_kidx(in_kidx),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
        .out_err(out_err), .busy(busy)
    );

    ark_engine #(.LANE_W(8), .NUM_KEYS(NUM_KEYS), .KIDX_W(KIDX_W)) u_l8 (
        .clk(clk), .rst_n(rst_n), .key_we(key_we), .key_widx(key_widx), .key_wdata(key_wdata),
        .in_valid(in_valid_8), .in_ready(in_ready_8), .in_state(in_state), .in_kidx(in_kidx),
        .out_valid(out_valid_8), .out_ready(1'b1), .out_state(out_state_8),
        .out_err(out_err_8), .busy(busy_8)
    );

    ark_engine #(.LANE_W(128), .NUM_KEYS(NUM_KEYS), .KIDX_W(KIDX_W)) u_l128 (
        .clk(clk), .rst_n(rst_n), .key_we(key_we), .key_widx(key_widx), .key_wdata(key_wdata),
        .in_valid(in_valid_128), .in_ready(in_ready_128), .in_state(in_state), .in_kidx(in_kidx),
        .out_valid(out_valid_128), .out_ready(1'b1), .out_state(out_state_128),
        .out_err(out_err_128), .busy(busy_128)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_key(input logic [KIDX_W-1:0] idx, input aes_block_t k);
        key_we    = 1'b1;
        key_widx  = idx;
        key_wdata = k;
        tick();
        key_we    = 1'b0;
    endtask

    // Present a state to the 32-bit engine and return just after the accept edge.
    task automatic send(input aes_block_t st, input logic [KIDX_W-1:0] kidx);
        int n = 0;
        in_valid = 1'b1;
        in_state = st;
        in_kidx  = kidx;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("in_ready_before_accept", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
    endtask

    // Count cycles until out_valid and compare with the expected latency.
    task automatic wait_out(input string tag, input int exp_lat);
        int n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check(tag, n, exp_lat);
    endtask

    // Pop the oldest expectation and compare it against the held result, then take it.
    task automatic drain(input string tag);
        exp_t e;
        e.st  = 'x;
        e.err = 1'bx;
        if (sb.size() > 0) e = sb.pop_front();
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_state"}, out_state, e.st);
        check({tag, "_err"}, out_err, e.err);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        aes_block_t s1, s2, s3, s4, s5, s6, s7, s8;
        aes_block_t k_old, k_a, k_b;
        int n;

        s1    = 128'h00112233445566778899aabbccddeeff;
        s2    = 128'hdeadbeefcafef00d0123456789abcdef;
        s3    = 128'h0f0e0d0c0b0a09080706050403020100;
        s4    = 128'ha5a5a5a55a5a5a5af0f0f0f00f0f0f0f;
        s5    = 128'h123456789abcdef0123456789abcdef0;
        s6    = 128'h55555555aaaaaaaa33333333cccccccc;
        s7    = 128'h89abcdef0123456776543210fedcba98;
        s8    = 128'hfedcba9876543210fedcba9876543210;
        k_old = 128'h1111222233334444555566667777_8888;
        k_a   = 128'haaaaaaaabbbbbbbbccccccccdddddddd;
        k_b   = 128'h0123456789abcdeffedcba9876543210;

        rst_n        = 1'b0;
        key_we       = 1'b0;
        key_widx     = '0;
        key_wdata    = '0;
        in_valid     = 1'b0;
        in_valid_8   = 1'b0;
        in_valid_128 = 1'b0;
        in_state     = '0;
        in_kidx      = '0;
        out_ready    = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_err", out_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_out_state", out_state, '0);
        rst_n = 1'b1;
        #1;
        check("rst_release_in_ready", in_ready, 1'b1);
        tick();

        // FIPS-197 round 0 on the 32-bit engine, latency 4
        write_key(4'd0, FIPS_KEY);
        send(FIPS_PT, 4'd0);
        sb.push_back('{st: FIPS_CT, err: 1'b0});
        check("fips_busy", busy, 1'b1);
        wait_out("lat32", 4);
        drain("fips32");

        // Latency sweep: LANE_W=8 and LANE_W=128
        in_state = FIPS_PT;
        in_kidx  = 4'd0;
        check("l8_in_ready", in_ready_8, 1'b1);
        in_valid_8 = 1'b1;
        tick();
        in_valid_8 = 1'b0;
        n = 0;
        while (!out_valid_8 && n < 100) begin
            tick();
            n++;
        end
        check("lat8", n, 16);
        check("l8_state", out_state_8, FIPS_CT);

        check("l128_in_ready", in_ready_128, 1'b1);
        in_valid_128 = 1'b1;
        tick();
        in_valid_128 = 1'b0;
        n = 0;
        while (!out_valid_128 && n < 100) begin
            tick();
            n++;
        end
        check("lat128", n, 1);
        check("l128_state", out_state_128, FIPS_CT);
        tick();

        // Backpressure for 10 cycles with a pending input, then back-to-back accept
        send(s1, 4'd0);
        sb.push_back('{st: s1 ^ FIPS_KEY, err: 1'b0});
        wait_out("lat_bp", 4);
        in_valid = 1'b1;
        in_state = s2;
        in_kidx  = 4'd0;
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_out_state", out_state, s1 ^ FIPS_KEY);
            check("bp_in_ready", in_ready, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("b2b_in_ready", in_ready, 1'b1);
        begin
            exp_t e;
            e = sb.pop_front();
            check("b2b_first_state", out_state, e.st);
            check("b2b_first_err", out_err, e.err);
        end
        sb.push_back('{st: s2 ^ FIPS_KEY, err: 1'b0});
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_not_valid", out_valid, 1'b0);
        check("b2b_busy", busy, 1'b1);
        wait_out("lat_b2b", 4);
        drain("b2b_second");

        // Key hazard: same-cycle write+accept uses the old key; write during XOR is ignored
        write_key(4'd3, k_old);
        key_we    = 1'b1;
        key_widx  = 4'd3;
        key_wdata = k_a;
        send(s3, 4'd3);
        sb.push_back('{st: s3 ^ k_old, err: 1'b0});
        key_wdata = k_b;
        tick();
        key_we = 1'b0;
        wait_out("lat_hazard", 3);
        drain("hazard");
        send(s4, 4'd3);
        sb.push_back('{st: s4 ^ k_b, err: 1'b0});
        wait_out("lat_followup", 4);
        drain("followup");

        // Out-of-range index: ignored write, zero key, out_err for that result only
        write_key(4'd15, k_a);
        send(s5, 4'd15);
        sb.push_back('{st: s5, err: 1'b1});
        wait_out("lat_oor", 4);
        drain("oor");
        check("oor_err_cleared", out_err, 1'b0);
        send(s6, 4'd0);
        sb.push_back('{st: s6 ^ FIPS_KEY, err: 1'b0});
        wait_out("lat_after_oor", 4);
        drain("after_oor");

        // Reset at beat 2 of XOR: no output, bank cleared, ready after release
        send(s7, 4'd0);
        tick();
        tick();
        check("mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_out_state", out_state, '0);
        tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);
        send(s8, 4'd0);
        sb.push_back('{st: s8, err: 1'b0});
        wait_out("lat_post_rst", 4);
        drain("post_rst_zero_key");
        check("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
